// File: rtl/dmem_arbiter.sv
// Arbiter sharing the single-ported data memory between the load unit and the store buffer.
// Checks alignment/range at accept, holds memory controls for the full latency, and aborts on timeout.
module dmem_arbiter #(
    parameter int unsigned MEM_SIZE_BYTES = 8192,
    parameter int unsigned TAG_WIDTH      = 4,
    parameter int unsigned STARVE_LIMIT   = 4,
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 ld_req_valid,
    output logic                 ld_req_ready,
    input  logic [31:0]          ld_req_addr,
    input  logic                 ld_req_byte,
    input  logic                 ld_req_signed,
    input  logic [TAG_WIDTH-1:0] ld_req_tag,
    output logic                 ld_resp_valid,
    output logic [31:0]          ld_resp_data,
    output logic [TAG_WIDTH-1:0] ld_resp_tag,
    output logic                 ld_resp_err,
    input  logic                 st_req_valid,
    output logic                 st_req_ready,
    input  logic [31:0]          st_req_addr,
    input  logic [31:0]          st_req_data,
    input  logic                 st_req_byte,
    output logic                 st_resp_valid,
    output logic                 st_resp_err,
    output logic                 mem_read_enable,
    output logic                 mem_write_enable,
    output logic [31:0]          mem_read_address,
    output logic [31:0]          mem_write_address,
    output logic [31:0]          mem_write_value,
    output logic                 mem_load_byte,
    output logic                 mem_store_byte,
    input  logic [31:0]          mem_read_value,
    input  logic                 mem_read_valid,
    input  logic                 mem_write_valid,
    output logic                 timeout_err
);

    localparam int unsigned SC_W = $clog2(STARVE_LIMIT + 1);
    localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [32:0]     MEM_LIMIT  = 33'(MEM_SIZE_BYTES);
    localparam logic [SC_W-1:0] STARVE_MAX = SC_W'(STARVE_LIMIT);
    localparam logic [TO_W-1:0] TO_LAST    = TO_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LD_WAIT = 2'd1,
        ST_WAIT = 2'd2
    } state_t;

    state_t                 state_r;
    state_t                 state_s;
    logic [SC_W-1:0]        starve_cnt_r;
    logic [TO_W-1:0]        timeout_cnt_r;
    logic                   ld_signed_r;
    logic [TAG_WIDTH-1:0]   ld_tag_r;
    logic                   ld_grant_s;
    logic                   st_grant_s;
    logic                   ld_err_s;
    logic                   st_err_s;
    logic                   in_wait_s;
    logic                   wait_done_s;
    logic                   timeout_hit_s;

    // Address is widened to 33 bits so addr+3 cannot wrap past the range limit.
    function automatic logic access_err(input logic [31:0] addr, input logic is_byte);
        logic [32:0] addr_w;
        addr_w = {1'b0, addr};
        if (addr_w >= MEM_LIMIT) begin
            access_err = 1'b1;
        end else if (!is_byte && ((addr[1:0] != 2'b00) || ((addr_w + 33'd3) >= MEM_LIMIT))) begin
            access_err = 1'b1;
        end else begin
            access_err = 1'b0;
        end
    endfunction

    function automatic logic [31:0] fmt_load(input logic [31:0] d, input logic is_byte,
                                             input logic sgn);
        if (!is_byte) begin
            fmt_load = d;
        end else if (sgn) begin
            fmt_load = {{24{d[7]}}, d[7:0]};
        end else begin
            fmt_load = {24'd0, d[7:0]};
        end
    endfunction

    assign ld_err_s = access_err(ld_req_addr, ld_req_byte);
    assign st_err_s = access_err(st_req_addr, st_req_byte);

    assign in_wait_s     = (state_r == LD_WAIT) || (state_r == ST_WAIT);
    assign wait_done_s   = ((state_r == LD_WAIT) && mem_read_valid) ||
                           ((state_r == ST_WAIT) && mem_write_valid);
    assign timeout_hit_s = in_wait_s && !wait_done_s && (timeout_cnt_r == TO_LAST);

    // Enables drop the same cycle the memory answers so its latency counter is not re-armed.
    assign mem_read_enable  = (state_r == LD_WAIT) && !mem_read_valid;
    assign mem_write_enable = (state_r == ST_WAIT) && !mem_write_valid;

    assign ld_req_ready = ld_grant_s;
    assign st_req_ready = st_grant_s;

    // Grant selection: loads win unless the pending store has been starved long enough.
    always_comb begin
        ld_grant_s = 1'b0;
        st_grant_s = 1'b0;
        if ((state_r == IDLE) && reset_n) begin
            if (ld_req_valid && !(st_req_valid && (starve_cnt_r == STARVE_MAX))) begin
                ld_grant_s = 1'b1;
            end else if (st_req_valid) begin
                st_grant_s = 1'b1;
            end else begin
                ld_grant_s = 1'b0;
                st_grant_s = 1'b0;
            end
        end else begin
            ld_grant_s = 1'b0;
            st_grant_s = 1'b0;
        end
    end

    // Next-state logic; errored requests are answered without leaving IDLE.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (ld_grant_s && !ld_err_s) begin
                    state_s = LD_WAIT;
                end else if (st_grant_s && !st_err_s) begin
                    state_s = ST_WAIT;
                end else begin
                    state_s = IDLE;
                end
            end
            LD_WAIT: begin
                if (mem_read_valid || timeout_hit_s) begin
                    state_s = IDLE;
                end else begin
                    state_s = LD_WAIT;
                end
            end
            ST_WAIT: begin
                if (mem_write_valid || timeout_hit_s) begin
                    state_s = IDLE;
                end else begin
                    state_s = ST_WAIT;
                end
            end
            default: state_s = IDLE;
        endcase
    end

    // State register, starvation and timeout counters.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r       <= IDLE;
            starve_cnt_r  <= '0;
            timeout_cnt_r <= '0;
            timeout_err   <= 1'b0;
        end else begin
            state_r <= state_s;
            if (!st_req_valid || st_grant_s) begin
                starve_cnt_r <= '0;
            end else if (ld_grant_s) begin
                starve_cnt_r <= starve_cnt_r + SC_W'(1);
            end else begin
                starve_cnt_r <= starve_cnt_r;
            end
            if (in_wait_s && !wait_done_s && !timeout_hit_s) begin
                timeout_cnt_r <= timeout_cnt_r + TO_W'(1);
            end else begin
                timeout_cnt_r <= '0;
            end
            if (timeout_hit_s) begin
                timeout_err <= 1'b1;
            end else begin
                timeout_err <= timeout_err;
            end
        end
    end

    // Memory-side request registers, loaded only on an error-free grant.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mem_read_address  <= 32'd0;
            mem_load_byte     <= 1'b0;
            ld_signed_r       <= 1'b0;
            ld_tag_r          <= '0;
            mem_write_address <= 32'd0;
            mem_write_value   <= 32'd0;
            mem_store_byte    <= 1'b0;
        end else begin
            if (ld_grant_s && !ld_err_s) begin
                mem_read_address <= ld_req_addr;
                mem_load_byte    <= ld_req_byte;
                ld_signed_r      <= ld_req_signed;
                ld_tag_r         <= ld_req_tag;
            end else begin
                mem_read_address <= mem_read_address;
            end
            if (st_grant_s && !st_err_s) begin
                mem_write_address <= st_req_addr;
                mem_write_value   <= st_req_data;
                mem_store_byte    <= st_req_byte;
            end else begin
                mem_write_address <= mem_write_address;
            end
        end
    end

    // Response pulses; data, tag and err are only meaningful while the pulse is high.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ld_resp_valid <= 1'b0;
            ld_resp_data  <= 32'd0;
            ld_resp_tag   <= '0;
            ld_resp_err   <= 1'b0;
            st_resp_valid <= 1'b0;
            st_resp_err   <= 1'b0;
        end else begin
            ld_resp_valid <= 1'b0;
            ld_resp_data  <= 32'd0;
            ld_resp_tag   <= '0;
            ld_resp_err   <= 1'b0;
            st_resp_valid <= 1'b0;
            st_resp_err   <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (ld_grant_s && ld_err_s) begin
                        ld_resp_valid <= 1'b1;
                        ld_resp_err   <= 1'b1;
                        ld_resp_tag   <= ld_req_tag;
                    end else if (st_grant_s && st_err_s) begin
                        st_resp_valid <= 1'b1;
                        st_resp_err   <= 1'b1;
                    end else begin
                        ld_resp_valid <= 1'b0;
                    end
                end
                LD_WAIT: begin
                    if (mem_read_valid) begin
                        ld_resp_valid <= 1'b1;
                        ld_resp_data  <= fmt_load(mem_read_value, mem_load_byte, ld_signed_r);
                        ld_resp_tag   <= ld_tag_r;
                    end else if (timeout_hit_s) begin
                        ld_resp_valid <= 1'b1;
                        ld_resp_err   <= 1'b1;
                        ld_resp_tag   <= ld_tag_r;
                    end else begin
                        ld_resp_valid <= 1'b0;
                    end
                end
                ST_WAIT: begin
                    if (mem_write_valid) begin
                        st_resp_valid <= 1'b1;
                    end else if (timeout_hit_s) begin
                        st_resp_valid <= 1'b1;
                        st_resp_err   <= 1'b1;
                    end else begin
                        st_resp_valid <= 1'b0;
                    end
                end
                default: ld_resp_valid <= 1'b0;
            endcase
        end
    end

endmodule
